// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM command port between camera writes, VGA reads and auto-refresh,
// and generates burst addresses for a double-buffered frame store.
module sdram_arbiter #(
    parameter int unsigned BURST_LEN      = 256,
    parameter int unsigned FRAME_WORDS    = 307200,
    parameter int unsigned FRAME_BASE     = 524288,
    parameter int unsigned REFRESH_CYCLES = 780,
    parameter int unsigned RD_LOW_MARK    = 256,
    parameter int unsigned ADDR_W         = 24,
    parameter int unsigned LVL_W          = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic              wr_frame_start,
    input  logic [LVL_W-1:0]  rd_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_space,
    input  logic              rd_frame_start,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_done,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned TMR_W = $clog2(REFRESH_CYCLES);

    localparam logic [LVL_W-1:0]  BURST_LVL = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  LOW_LVL   = LVL_W'(RD_LOW_MARK);
    localparam logic [PTR_W-1:0]  BURST_PTR = PTR_W'(BURST_LEN);
    localparam logic [PTR_W-1:0]  FRAME_PTR = PTR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FRAME_BASE);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_CYCLES - 1);

    localparam logic [1:0] CMD_WR  = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic               refresh_pending;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               wr_active;
    logic               rd_active;
    logic               wr_full;
    logic               rd_full;
    logic               last_done;
    logic               last_rd;

    logic               wr_ok;
    logic               rd_ok;
    logic               rd_urgent;
    logic               accept;
    logic               tmr_expire;
    logic               gnt;
    logic [1:0]         gnt_type;
    logic [ADDR_W-1:0]  gnt_addr;
    logic [PTR_W-1:0]   wr_ptr_nxt;
    logic [PTR_W-1:0]   rd_ptr_nxt;

    // Request eligibility and the grant decision taken in IDLE
    always_comb begin
        wr_ok      = wr_active && !wr_full && (wr_fifo_level >= BURST_LVL);
        rd_ok      = rd_active && !rd_full && (rd_fifo_space >= BURST_LVL);
        rd_urgent  = rd_ok && (rd_fifo_level < LOW_LVL);
        accept     = (state == ST_ISSUE) && cmd_ready;
        tmr_expire = (tmr == TMR_LAST);
        wr_ptr_nxt = wr_ptr + BURST_PTR;
        rd_ptr_nxt = rd_ptr + BURST_PTR;
        gnt        = 1'b0;
        gnt_type   = CMD_WR;
        gnt_addr   = '0;
        if (refresh_pending) begin
            gnt      = 1'b1;
            gnt_type = CMD_REF;
        end else if (rd_urgent || (rd_ok && !(wr_ok && last_rd))) begin
            // A non-urgent read yields to a write only when the previous grant was a read
            gnt      = 1'b1;
            gnt_type = CMD_RD;
            gnt_addr = (rd_bank ? BASE_ADDR : '0) + ADDR_W'(rd_ptr);
        end else if (wr_ok) begin
            gnt      = 1'b1;
            gnt_type = CMD_WR;
            gnt_addr = (wr_bank ? BASE_ADDR : '0) + ADDR_W'(wr_ptr);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= ST_IDLE;
            cmd_valid       <= 1'b0;
            cmd_type        <= CMD_WR;
            cmd_addr        <= '0;
            busy            <= 1'b0;
            tmr             <= '0;
            refresh_pending <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            wr_active       <= 1'b0;
            rd_active       <= 1'b0;
            wr_full         <= 1'b0;
            rd_full         <= 1'b0;
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b0;
            last_done       <= 1'b0;
            last_rd         <= 1'b1;
        end else begin
            tmr <= tmr_expire ? '0 : tmr + TMR_W'(1);

            if (accept && cmd_type == CMD_REF) begin
                refresh_pending <= 1'b0;
            end
            if (tmr_expire) begin
                refresh_pending <= 1'b1;
            end

            if (accept && cmd_type == CMD_WR) begin
                wr_ptr  <= wr_ptr_nxt;
                wr_full <= (wr_ptr_nxt == FRAME_PTR);
                last_rd <= 1'b0;
            end
            if (accept && cmd_type == CMD_RD) begin
                rd_ptr  <= rd_ptr_nxt;
                rd_full <= (rd_ptr_nxt == FRAME_PTR);
                last_rd <= 1'b1;
            end

            // Frame starts override any same-cycle pointer advance
            if (wr_frame_start) begin
                wr_active <= 1'b1;
                wr_ptr    <= '0;
                wr_full   <= 1'b0;
                if (wr_full) begin
                    last_done <= wr_bank;
                    wr_bank   <= ~wr_bank;
                end
            end
            if (rd_frame_start) begin
                rd_active <= 1'b1;
                rd_ptr    <= '0;
                rd_full   <= 1'b0;
                rd_bank   <= last_done;
            end

            case (state)
                ST_IDLE: begin
                    if (gnt) begin
                        state     <= ST_ISSUE;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        cmd_type  <= gnt_type;
                        cmd_addr  <= gnt_addr;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        state     <= ST_WAIT;
                        cmd_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cmd_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vector table, refresh/partial-frame sequences,
// and randomized traffic compared every cycle against a transaction-level model.
module tb_sdram_arbiter;

    localparam int BURST  = 4;
    localparam int FRAME  = 16;
    localparam int BASE   = 64;
    localparam int REF    = 40;
    localparam int LOW    = 4;
    localparam int NB     = FRAME / BURST;

    logic        CLK;
    logic        RST;
    logic [9:0]  wr_fifo_level;
    logic        wr_frame_start;
    logic [9:0]  rd_fifo_level;
    logic [9:0]  rd_fifo_space;
    logic        rd_frame_start;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [23:0] cmd_addr;
    logic        cmd_done;
    logic        wr_bank;
    logic        rd_bank;
    logic        busy;

    int errors = 0;
    int checks = 0;

    sdram_arbiter #(
        .BURST_LEN(BURST), .FRAME_WORDS(FRAME), .FRAME_BASE(BASE),
        .REFRESH_CYCLES(REF), .RD_LOW_MARK(LOW), .ADDR_W(24), .LVL_W(10)
    ) dut (
        .CLK(CLK), .RST(RST),
        .wr_fifo_level(wr_fifo_level), .wr_frame_start(wr_frame_start),
        .rd_fifo_level(rd_fifo_level), .rd_fifo_space(rd_fifo_space),
        .rd_frame_start(rd_frame_start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_done(cmd_done),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .busy(busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model: command phase (0 none, 1 offered, 2 in flight), bursts done per frame, bank numbers
    int m_phase, m_type, m_addr, m_wbn, m_rbn, m_wbank, m_rbank, m_last_done, m_cyc;
    bit m_wact, m_ract, m_last_rd, m_pend;

    function automatic void model_step();
        bit wok, rok, urg, acc, expire;
        int o_wbn, o_last_done;
        if (RST) begin
            m_phase = 0; m_type = 0; m_addr = 0; m_wbn = 0; m_rbn = 0;
            m_wbank = 0; m_rbank = 0; m_last_done = 0; m_cyc = 0;
            m_wact = 0; m_ract = 0; m_last_rd = 1; m_pend = 0;
            return;
        end
        wok    = m_wact && (m_wbn < NB) && (int'(wr_fifo_level) >= BURST);
        rok    = m_ract && (m_rbn < NB) && (int'(rd_fifo_space) >= BURST);
        urg    = rok && (int'(rd_fifo_level) < LOW);
        acc    = (m_phase == 1) && cmd_ready;
        expire = (m_cyc % REF) == REF - 1;
        o_wbn = m_wbn;
        o_last_done = m_last_done;

        if (m_phase == 0) begin
            if (m_pend) begin
                m_phase = 1; m_type = 2; m_addr = 0;
            end else if (urg || (rok && !wok) || (rok && wok && !m_last_rd)) begin
                m_phase = 1; m_type = 1; m_addr = m_rbank * BASE + m_rbn * BURST;
            end else if (wok) begin
                m_phase = 1; m_type = 0; m_addr = m_wbank * BASE + m_wbn * BURST;
            end
        end else if (m_phase == 1) begin
            if (cmd_ready) m_phase = 2;
        end else if (cmd_done) begin
            m_phase = 0;
        end

        if (acc) begin
            if (m_type == 0) begin m_wbn++; m_last_rd = 0; end
            if (m_type == 1) begin m_rbn++; m_last_rd = 1; end
            if (m_type == 2) m_pend = 0;
        end
        if (expire) m_pend = 1;
        m_cyc++;

        if (wr_frame_start) begin
            if (o_wbn == NB) begin
                m_last_done = m_wbank;
                m_wbank = 1 - m_wbank;
            end
            m_wbn = 0;
            m_wact = 1;
        end
        if (rd_frame_start) begin
            m_rbank = o_last_done;
            m_rbn = 0;
            m_ract = 1;
        end
    endfunction

    function automatic logic [29:0] model_vec();
        return {m_phase == 1, m_phase != 0, 2'(m_type), 24'(m_addr), 1'(m_wbank), 1'(m_rbank)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
        check("model", 64'({cmd_valid, busy, cmd_type, cmd_addr, wr_bank, rd_bank}), 64'(model_vec()));
    endtask

    task automatic wait_offer(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cmd_valid) begin
                got = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Accept the offered command now and signal completion three cycles later
    task automatic finish_cmd();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        step();
        step();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
    endtask

    task automatic get_cmd(output int typ, output int addr, output bit got);
        got = 1'b0;
        typ = -1;
        addr = -1;
        for (int n = 0; n < 8; n++) begin
            wait_offer(got);
            if (!got) return;
            typ = int'(cmd_type);
            addr = int'(cmd_addr);
            finish_cmd();
            if (typ != 2) return;
            check("refresh_addr", 64'(addr), 64'(0));
            got = 1'b0;
        end
    endtask

    typedef struct {
        int wl; int rl; int rs; bit wfs; bit rfs;
        int typ; int addr; int wb; int rb;
    } vec_t;

    vec_t tbl[19];

    initial begin
        bit got;
        int typ, addr, writes;

        tbl[0]  = '{8, 0, 0,  1, 0, 0, 0,  0, 0};
        tbl[1]  = '{8, 0, 0,  0, 0, 0, 4,  0, 0};
        tbl[2]  = '{8, 0, 0,  0, 0, 0, 8,  0, 0};
        tbl[3]  = '{8, 0, 0,  0, 0, 0, 12, 0, 0};
        tbl[4]  = '{8, 0, 0,  1, 0, 0, 64, 1, 0};
        tbl[5]  = '{8, 8, 16, 0, 1, 1, 0,  1, 0};
        tbl[6]  = '{8, 8, 16, 0, 0, 0, 68, 1, 0};
        tbl[7]  = '{8, 8, 16, 0, 0, 1, 4,  1, 0};
        tbl[8]  = '{8, 8, 16, 0, 0, 0, 72, 1, 0};
        tbl[9]  = '{8, 8, 16, 0, 0, 1, 8,  1, 0};
        tbl[10] = '{8, 8, 16, 0, 0, 0, 76, 1, 0};
        tbl[11] = '{8, 8, 16, 0, 0, 1, 12, 1, 0};
        tbl[12] = '{8, 2, 16, 1, 1, 1, 64, 0, 1};
        tbl[13] = '{8, 2, 16, 0, 0, 1, 68, 0, 1};
        tbl[14] = '{8, 8, 16, 0, 0, 0, 0,  0, 1};
        tbl[15] = '{8, 0, 0,  1, 0, 0, 0,  0, 1};
        tbl[16] = '{8, 0, 0,  0, 0, 0, 4,  0, 1};
        tbl[17] = '{8, 0, 0,  1, 0, 0, 0,  0, 1};
        tbl[18] = '{0, 8, 16, 0, 1, 1, 64, 0, 1};

        RST = 1'b1;
        wr_fifo_level = '0; rd_fifo_level = '0; rd_fifo_space = '0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        cmd_ready = 1'b0; cmd_done = 1'b0;

        // Reset and first refresh timing
        step();
        step();
        RST = 1'b0;
        check("reset_outputs", 64'({cmd_valid, busy, cmd_type, cmd_addr, wr_bank, rd_bank}), 64'(0));
        for (int i = 0; i < 40; i++) step();
        check("refresh_not_yet", 64'(cmd_valid), 64'(0));
        step();
        check("first_refresh", 64'({cmd_valid, cmd_type, cmd_addr}), 64'({1'b1, 2'b10, 24'd0}));
        finish_cmd();

        for (int i = 0; i < 19; i++) begin
            wr_fifo_level = '0; rd_fifo_space = '0; rd_fifo_level = '0;
            if (tbl[i].wfs) begin
                wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
            end
            if (tbl[i].rfs) begin
                rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
            end
            wr_fifo_level = 10'(tbl[i].wl);
            rd_fifo_level = 10'(tbl[i].rl);
            rd_fifo_space = 10'(tbl[i].rs);
            get_cmd(typ, addr, got);
            check($sformatf("vec%0d_offer", i), 64'(got), 64'(1));
            check($sformatf("vec%0d_type", i), 64'(typ), 64'(tbl[i].typ));
            check($sformatf("vec%0d_addr", i), 64'(addr), 64'(tbl[i].addr));
            check($sformatf("vec%0d_banks", i), 64'({wr_bank, rd_bank}), 64'({1'(tbl[i].wb), 1'(tbl[i].rb)}));

            if (i == 3) begin
                // Frame fully written: only refreshes may follow
                writes = 0;
                for (int c = 0; c < 60; c++) begin
                    if (cmd_valid) begin
                        if (cmd_type == 2'b00) writes++;
                        finish_cmd();
                    end else begin
                        step();
                    end
                end
                check("no_write_after_full", 64'(writes), 64'(0));
            end

            if (i == 14) begin
                // Refresh expiry coinciding with pending write and urgent read
                wr_fifo_level = 10'd8; rd_fifo_level = 10'd8; rd_fifo_space = 10'd16;
                wait_offer(got);
                check("collide_first_offer", 64'(got), 64'(1));
                cmd_ready = 1'b1;
                step();
                cmd_ready = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    if ((m_cyc % REF) == REF - 1) break;
                    step();
                end
                rd_fifo_level = 10'd2;
                step();
                cmd_done = 1'b1;
                step();
                cmd_done = 1'b0;
                step();
                check("collide_refresh_first", 64'({cmd_valid, cmd_type, cmd_addr}), 64'({1'b1, 2'b10, 24'd0}));
                for (int c = 0; c < 50; c++) begin
                    step();
                    check("refresh_held", 64'({cmd_valid, cmd_type, cmd_addr}), 64'({1'b1, 2'b10, 24'd0}));
                end
                finish_cmd();
                wait_offer(got);
                check("after_refresh_offer", 64'(got), 64'(1));
                check("after_refresh_is_read", 64'(cmd_type), 64'(1));
                finish_cmd();
            end
        end

        // Randomized traffic, checked every cycle against the model
        for (int c = 0; c < 3000; c++) begin
            RST            = ($urandom_range(0, 399) == 0);
            wr_fifo_level  = 10'($urandom_range(0, 12));
            rd_fifo_level  = 10'($urandom_range(0, 10));
            rd_fifo_space  = 10'($urandom_range(0, 20));
            wr_frame_start = ($urandom_range(0, 59) == 0);
            rd_frame_start = ($urandom_range(0, 59) == 0);
            cmd_ready      = ($urandom_range(0, 1) == 1);
            cmd_done       = ($urandom_range(0, 3) == 0);
            step();
        end
        RST = 1'b0;
        wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        cmd_ready = 1'b0; cmd_done = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
